axis_packet_merger: RTL and testbench

- Downstream counterpart of the per-interface broadcast FIFOs: collects the S_INTF_NUM AXI-Stream outputs of the parallel processing instances and merges them packet-atomically, round-robin, into one egress stream.
- During live migration, one interface selected by dpr_intf is diverted to a dedicated m_axis_dpr output and excluded from the egress arbitration, so its migration traffic is captured separately.

---
 rtl/axis_packet_merger_pkg.sv | 18 +
 rtl/axis_packet_merger_reg_slice.sv | 43 ++++
 rtl/axis_packet_merger.sv | 180 ++++++++++++++++++
 tb/tb_axis_packet_merger.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_packet_merger_pkg.sv
// Shared types and helpers for the AXI-Stream packet merger.
// Egress FSM encoding, grant index sizing and packed-bus slice offsets.
package axis_packet_merger_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } egress_state_t;

  function automatic int grant_width(input int intf_num);
    return (intf_num > 1) ? $clog2(intf_num) : 1;
  endfunction

  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/axis_packet_merger_reg_slice.sv
// One-stage AXI-Stream output register with full throughput.
// A beat loads whenever the register is empty or being drained in the same cycle.
module axis_reg_slice #(
  parameter int DATA_WIDTH = 512,
  parameter int USER_WIDTH = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   in_tdata,
  input  logic [DATA_WIDTH/8-1:0] in_tkeep,
  input  logic [USER_WIDTH-1:0]   in_tuser,
  input  logic                    in_tlast,
  input  logic                    in_tvalid,
  output logic                    in_tready,
  output logic [DATA_WIDTH-1:0]   out_tdata,
  output logic [DATA_WIDTH/8-1:0] out_tkeep,
  output logic [USER_WIDTH-1:0]   out_tuser,
  output logic                    out_tlast,
  output logic                    out_tvalid,
  input  logic                    out_tready
);

  assign in_tready = !out_tvalid || out_tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_tdata  <= '0;
      out_tkeep  <= '0;
      out_tuser  <= '0;
      out_tlast  <= 1'b0;
      out_tvalid <= 1'b0;
    end else if (in_tvalid && in_tready) begin
      out_tdata  <= in_tdata;
      out_tkeep  <= in_tkeep;
      out_tuser  <= in_tuser;
      out_tlast  <= in_tlast;
      out_tvalid <= 1'b1;
    end else if (out_tready) begin
      out_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_packet_merger.sv
// Packet-atomic round-robin merge of S_INTF_NUM AXI-Stream inputs onto one egress,
// with one optionally diverted interface routed to a dedicated migration output.
module axis_packet_merger
  import axis_packet_merger_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH  = 512,
  parameter int AXIS_TUSER_WIDTH = 256,
  parameter int S_INTF_NUM       = 7
) (
  input  logic                                       aclk,
  input  logic                                       areset,
  input  logic [S_INTF_NUM-1:0]                      dpr_intf,
  input  logic                                       dpr_intf_valid,
  output logic                                       dpr_active,
  input  logic [S_INTF_NUM*AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [S_INTF_NUM*AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
  input  logic [S_INTF_NUM*AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
  input  logic [S_INTF_NUM-1:0]                      s_axis_tvalid,
  output logic [S_INTF_NUM-1:0]                      s_axis_tready,
  input  logic [S_INTF_NUM-1:0]                      s_axis_tlast,
  output logic [AXIS_DATA_WIDTH-1:0]                 m_axis_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0]               m_axis_tkeep,
  output logic [AXIS_TUSER_WIDTH-1:0]                m_axis_tuser,
  output logic                                       m_axis_tvalid,
  input  logic                                       m_axis_tready,
  output logic                                       m_axis_tlast,
  output logic [AXIS_DATA_WIDTH-1:0]                 m_axis_dpr_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0]               m_axis_dpr_tkeep,
  output logic [AXIS_TUSER_WIDTH-1:0]                m_axis_dpr_tuser,
  output logic                                       m_axis_dpr_tvalid,
  input  logic                                       m_axis_dpr_tready,
  output logic                                       m_axis_dpr_tlast
);

  localparam int KEEP_WIDTH = AXIS_DATA_WIDTH / 8;
  localparam int GW         = grant_width(S_INTF_NUM);

  typedef logic [GW-1:0] idx_t;

  logic [AXIS_DATA_WIDTH-1:0]  s_data [S_INTF_NUM];
  logic [KEEP_WIDTH-1:0]       s_keep [S_INTF_NUM];
  logic [AXIS_TUSER_WIDTH-1:0] s_user [S_INTF_NUM];

  egress_state_t         state_q, state_d;
  idx_t                  grant_q, grant_d, rr_ptr_q, rr_ptr_d, pick, dpr_idx;
  logic                  found;
  logic [S_INTF_NUM-1:0] dpr_mask_q, dpr_mask_d, dpr_mask_req, eligible;
  logic                  mask_block, mask_change, dpr_open, dpr_mid_q;
  logic                  egr_in_valid, egr_in_ready, dpr_in_valid, dpr_in_ready;

  for (genvar i = 0; i < S_INTF_NUM; i++) begin : g_split
    assign s_data[i] = s_axis_tdata[slice_lo(i, AXIS_DATA_WIDTH) +: AXIS_DATA_WIDTH];
    assign s_keep[i] = s_axis_tkeep[slice_lo(i, KEEP_WIDTH) +: KEEP_WIDTH];
    assign s_user[i] = s_axis_tuser[slice_lo(i, AXIS_TUSER_WIDTH) +: AXIS_TUSER_WIDTH];
  end

  // A diversion change waits until neither stream is mid-packet on an affected interface
  // and the migration output register has drained, so no packet is ever split.
  always_comb begin
    dpr_mask_req = '0;
    if (dpr_intf_valid && $onehot(dpr_intf)) dpr_mask_req = dpr_intf;
    mask_block  = dpr_mid_q || m_axis_dpr_tvalid ||
                  (state_q == BUSY && (dpr_mask_q[grant_q] || dpr_mask_req[grant_q]));
    mask_change = !mask_block && (dpr_mask_req != dpr_mask_q);
    dpr_mask_d  = mask_change ? dpr_mask_req : dpr_mask_q;
    dpr_open    = dpr_active && !mask_change;
    dpr_idx     = '0;
    for (int i = 0; i < S_INTF_NUM; i++) begin
      if (dpr_mask_q[i]) dpr_idx = idx_t'(i);
    end
  end

  assign dpr_active   = |dpr_mask_q;
  assign dpr_in_valid = dpr_open && s_axis_tvalid[dpr_idx];
  assign eligible     = s_axis_tvalid & ~(dpr_mask_q | dpr_mask_d);

  always_comb begin
    int   cand;
    idx_t cand_idx;
    found    = 1'b0;
    pick     = '0;
    cand     = 0;
    cand_idx = '0;
    for (int off = 0; off < S_INTF_NUM; off++) begin
      cand = int'(rr_ptr_q) + off;
      if (cand >= S_INTF_NUM) cand = cand - S_INTF_NUM;
      cand_idx = idx_t'(cand);
      if (!found && eligible[cand_idx]) begin
        found = 1'b1;
        pick  = cand_idx;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    egr_in_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        egr_in_valid = s_axis_tvalid[grant_q];
        if (egr_in_valid && egr_in_ready && s_axis_tlast[grant_q]) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_q == idx_t'(S_INTF_NUM - 1)) ? '0 : grant_q + idx_t'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_axis_tready = '0;
    if (state_q == BUSY) s_axis_tready[grant_q] = egr_in_ready;
    if (dpr_open)        s_axis_tready[dpr_idx] = dpr_in_ready;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      dpr_mask_q <= '0;
      dpr_mid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      dpr_mask_q <= dpr_mask_d;
      if (dpr_in_valid && dpr_in_ready) dpr_mid_q <= !s_axis_tlast[dpr_idx];
    end
  end

  axis_reg_slice #(
    .DATA_WIDTH(AXIS_DATA_WIDTH),
    .USER_WIDTH(AXIS_TUSER_WIDTH)
  ) u_egress_slice (
    .clk       (aclk),
    .rst       (areset),
    .in_tdata  (s_data[grant_q]),
    .in_tkeep  (s_keep[grant_q]),
    .in_tuser  (s_user[grant_q]),
    .in_tlast  (s_axis_tlast[grant_q]),
    .in_tvalid (egr_in_valid),
    .in_tready (egr_in_ready),
    .out_tdata (m_axis_tdata),
    .out_tkeep (m_axis_tkeep),
    .out_tuser (m_axis_tuser),
    .out_tlast (m_axis_tlast),
    .out_tvalid(m_axis_tvalid),
    .out_tready(m_axis_tready)
  );

  axis_reg_slice #(
    .DATA_WIDTH(AXIS_DATA_WIDTH),
    .USER_WIDTH(AXIS_TUSER_WIDTH)
  ) u_dpr_slice (
    .clk       (aclk),
    .rst       (areset),
    .in_tdata  (s_data[dpr_idx]),
    .in_tkeep  (s_keep[dpr_idx]),
    .in_tuser  (s_user[dpr_idx]),
    .in_tlast  (s_axis_tlast[dpr_idx]),
    .in_tvalid (dpr_in_valid),
    .in_tready (dpr_in_ready),
    .out_tdata (m_axis_dpr_tdata),
    .out_tkeep (m_axis_dpr_tkeep),
    .out_tuser (m_axis_dpr_tuser),
    .out_tlast (m_axis_dpr_tlast),
    .out_tvalid(m_axis_dpr_tvalid),
    .out_tready(m_axis_dpr_tready)
  );

endmodule

// File: tb/tb_axis_packet_merger.sv
// Directed self-checking bench for axis_packet_merger: arbitration order, backpressure,
// diversion to the migration output, deferred diversion and asynchronous reset.
module tb_axis_packet_merger;

  localparam int DW = 512;
  localparam int UW = 256;
  localparam int N  = 7;
  localparam int KW = DW / 8;

  logic            aclk = 1'b0;
  logic            areset;
  logic [N-1:0]    dpr_intf;
  logic            dpr_intf_valid;
  logic            dpr_active;
  logic [N*DW-1:0] s_axis_tdata;
  logic [N*KW-1:0] s_axis_tkeep;
  logic [N*UW-1:0] s_axis_tuser;
  logic [N-1:0]    s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [DW-1:0]   m_axis_tdata, m_axis_dpr_tdata;
  logic [KW-1:0]   m_axis_tkeep, m_axis_dpr_tkeep;
  logic [UW-1:0]   m_axis_tuser, m_axis_dpr_tuser;
  logic            m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic            m_axis_dpr_tvalid, m_axis_dpr_tready, m_axis_dpr_tlast;

  logic [71:0] src_q [N][$];
  logic [71:0] egr_cap[$], dpr_cap[$], exp_egr[$], exp_dpr[$];
  int check_count = 0;
  int pass_count  = 0;

  always #5 aclk = ~aclk;

  axis_packet_merger #(
    .AXIS_DATA_WIDTH(DW),
    .AXIS_TUSER_WIDTH(UW),
    .S_INTF_NUM(N)
  ) dut (
    .aclk(aclk), .areset(areset),
    .dpr_intf(dpr_intf), .dpr_intf_valid(dpr_intf_valid), .dpr_active(dpr_active),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_dpr_tdata(m_axis_dpr_tdata), .m_axis_dpr_tkeep(m_axis_dpr_tkeep),
    .m_axis_dpr_tuser(m_axis_dpr_tuser), .m_axis_dpr_tvalid(m_axis_dpr_tvalid),
    .m_axis_dpr_tready(m_axis_dpr_tready), .m_axis_dpr_tlast(m_axis_dpr_tlast)
  );

  // Beat signature: {last, keep byte, user word, top data word, bottom data word}
  function automatic logic [71:0] mkBeat(input int iface, input int pkt, input int beat, input logic last);
    logic [15:0] d;
    d = {iface[3:0], pkt[3:0], beat[7:0]};
    return {7'b0, last, ~beat[7:0], d ^ 16'hC3C3, d, d};
  endfunction

  function automatic logic [71:0] egrWord();
    return {7'b0, m_axis_tlast, m_axis_tkeep[KW-1 -: 8], m_axis_tuser[UW-1 -: 16],
            m_axis_tdata[DW-1 -: 16], m_axis_tdata[15:0]};
  endfunction

  function automatic logic [71:0] dprWord();
    return {7'b0, m_axis_dpr_tlast, m_axis_dpr_tkeep[KW-1 -: 8], m_axis_dpr_tuser[UW-1 -: 16],
            m_axis_dpr_tdata[DW-1 -: 16], m_axis_dpr_tdata[15:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [71:0] got, input logic [71:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic applyStimulus(input int iface, input int pkt, input int nbeats);
    #1;
    for (int b = 0; b < nbeats; b++) src_q[iface].push_back(mkBeat(iface, pkt, b, b == nbeats - 1));
  endtask

  task automatic expectPacket(input logic to_dpr, input int iface, input int pkt, input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      if (to_dpr) exp_dpr.push_back(mkBeat(iface, pkt, b, b == nbeats - 1));
      else        exp_egr.push_back(mkBeat(iface, pkt, b, b == nbeats - 1));
    end
  endtask

  task automatic waitDone(input string tag, input int n_egr, input int n_dpr, input int budget);
    int cyc;
    cyc = 0;
    while ((egr_cap.size() < n_egr || dpr_cap.size() < n_dpr) && cyc < budget) begin
      waitCycles(1);
      cyc++;
    end
    checkOutput({tag, "_done"}, 72'(cyc < budget), 72'(1));
  endtask

  task automatic waitOutValid(input string tag);
    int cyc;
    cyc = 0;
    do begin
      @(negedge aclk);
      cyc++;
    end while (!m_axis_tvalid && cyc < 40);
    checkOutput({tag, "_seen"}, 72'(m_axis_tvalid), 72'(1));
  endtask

  task automatic checkStreams(input string tag);
    checkOutput({tag, "_egr_len"}, 72'(egr_cap.size()), 72'(exp_egr.size()));
    checkOutput({tag, "_dpr_len"}, 72'(dpr_cap.size()), 72'(exp_dpr.size()));
    for (int i = 0; i < exp_egr.size() && i < egr_cap.size(); i++)
      checkOutput($sformatf("%s_egr%0d", tag, i), egr_cap[i], exp_egr[i]);
    for (int i = 0; i < exp_dpr.size() && i < dpr_cap.size(); i++)
      checkOutput($sformatf("%s_dpr%0d", tag, i), dpr_cap[i], exp_dpr[i]);
    egr_cap.delete(); dpr_cap.delete(); exp_egr.delete(); exp_dpr.delete();
  endtask

  // Upstream sources: present the head of each queue, pop it after an accepted handshake
  initial begin
    logic [N-1:0] acc;
    logic [71:0]  w;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tuser = '0;
    s_axis_tvalid = '0; s_axis_tlast = '0;
    forever begin
      @(negedge aclk);
      acc = s_axis_tvalid & s_axis_tready;
      @(posedge aclk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        w = (src_q[i].size() > 0) ? src_q[i][0] : 72'(0);
        s_axis_tvalid[i] = (src_q[i].size() > 0);
        s_axis_tlast[i]  = w[56];
        s_axis_tdata[i*DW +: DW] = {32{w[15:0]}};
        s_axis_tuser[i*UW +: UW] = {16{w[47:32]}};
        s_axis_tkeep[i*KW +: KW] = {8{w[55:48]}};
      end
    end
  end

  // Output monitor: capture handshakes and require stalled egress data to hold
  initial begin
    logic        prev_stall;
    logic [71:0] prev_w, cur_w;
    prev_stall = 1'b0;
    prev_w = '0;
    forever begin
      @(negedge aclk);
      cur_w = egrWord();
      cur_w[71] = m_axis_tvalid;
      if (prev_stall && !areset) checkOutput("stall_hold", cur_w, prev_w);
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_w = cur_w;
      if (m_axis_tvalid && m_axis_tready) egr_cap.push_back(egrWord());
      if (m_axis_dpr_tvalid && m_axis_dpr_tready) dpr_cap.push_back(dprWord());
    end
  end

  initial begin
    int cyc;
    areset = 1'b1;
    dpr_intf = '0;
    dpr_intf_valid = 1'b0;
    m_axis_tready = 1'b1;
    m_axis_dpr_tready = 1'b1;
    #3;
    checkOutput("rst_m_tvalid", 72'(m_axis_tvalid), 72'(0));
    checkOutput("rst_dpr_tvalid", 72'(m_axis_dpr_tvalid), 72'(0));
    checkOutput("rst_s_tready", 72'(s_axis_tready), 72'(0));
    checkOutput("rst_dpr_active", 72'(dpr_active), 72'(0));
    waitCycles(3);
    areset = 1'b0;
    waitCycles(2);

    // Single 3-beat packet on interface 2: one bubble, output two cycles after tvalid
    $display("[TB] single packet");
    applyStimulus(2, 0, 3);
    expectPacket(0, 2, 0, 3);
    cyc = 0;
    do begin @(negedge aclk); cyc++; end while (!s_axis_tvalid[2] && cyc < 20);
    cyc = 0;
    while (!m_axis_tvalid && cyc < 20) begin @(negedge aclk); cyc++; end
    checkOutput("single_latency", 72'(cyc), 72'(2));
    waitDone("single", 3, 0, 40);
    checkStreams("single");

    // Pointer now 3: 3 before 0, then a lone 3 moves the pointer to 4
    $display("[TB] round robin");
    applyStimulus(0, 1, 1);
    applyStimulus(3, 1, 1);
    expectPacket(0, 3, 1, 1);
    expectPacket(0, 0, 1, 1);
    waitDone("rr_ptr3", 2, 0, 40);
    checkStreams("rr_ptr3");
    applyStimulus(3, 2, 1);
    expectPacket(0, 3, 2, 1);
    waitDone("rr_solo", 1, 0, 40);
    checkStreams("rr_solo");
    applyStimulus(0, 3, 2);
    applyStimulus(3, 3, 2);
    applyStimulus(6, 3, 2);
    expectPacket(0, 6, 3, 2);
    expectPacket(0, 0, 3, 2);
    expectPacket(0, 3, 3, 2);
    waitDone("rr_order", 6, 0, 60);
    checkStreams("rr_order");

    $display("[TB] backpressure");
    applyStimulus(0, 4, 4);
    expectPacket(0, 0, 4, 4);
    waitOutValid("bp");
    for (int i = 0; i < 6; i++) begin
      @(posedge aclk);
      #1;
      m_axis_tready = (i >= 2 && i != 3);
    end
    waitCycles(1);
    m_axis_tready = 1'b1;
    waitDone("bp", 4, 0, 40);
    checkStreams("bp");

    $display("[TB] diversion");
    waitCycles(1);
    dpr_intf = 7'b0000010;
    dpr_intf_valid = 1'b1;
    waitCycles(2);
    checkOutput("div_active", 72'(dpr_active), 72'(1));
    applyStimulus(1, 5, 2);
    applyStimulus(4, 5, 3);
    applyStimulus(1, 6, 2);
    expectPacket(1, 1, 5, 2);
    expectPacket(1, 1, 6, 2);
    expectPacket(0, 4, 5, 3);
    waitDone("div", 3, 4, 60);
    checkStreams("div");
    dpr_intf_valid = 1'b0;
    waitCycles(3);
    checkOutput("div_release", 72'(dpr_active), 72'(0));

    // Diversion of interface 5 requested while its egress packet is stalled mid-way
    $display("[TB] deferred switch");
    applyStimulus(5, 7, 4);
    expectPacket(0, 5, 7, 4);
    waitOutValid("defer");
    @(posedge aclk);
    #1;
    m_axis_tready = 1'b0;
    dpr_intf = 7'b0100000;
    dpr_intf_valid = 1'b1;
    waitCycles(3);
    checkOutput("defer_hold", 72'(dpr_active), 72'(0));
    m_axis_tready = 1'b1;
    waitDone("defer_egr", 4, 0, 40);
    waitCycles(2);
    checkOutput("defer_active", 72'(dpr_active), 72'(1));
    applyStimulus(5, 8, 2);
    expectPacket(1, 5, 8, 2);
    waitDone("defer_dpr", 4, 2, 40);
    checkStreams("defer");
    dpr_intf_valid = 1'b0;
    waitCycles(3);
    checkOutput("defer_release", 72'(dpr_active), 72'(0));

    $display("[TB] reset mid-packet");
    applyStimulus(6, 9, 4);
    waitOutValid("rstmid");
    @(posedge aclk);
    @(negedge aclk);
    #2;
    areset = 1'b1;
    for (int i = 0; i < N; i++) src_q[i].delete();
    #1;
    checkOutput("rstmid_m_tvalid", 72'(m_axis_tvalid), 72'(0));
    checkOutput("rstmid_s_tready", 72'(s_axis_tready), 72'(0));
    checkOutput("rstmid_dpr_tvalid", 72'(m_axis_dpr_tvalid), 72'(0));
    checkOutput("rstmid_m_tdata", 72'(m_axis_tdata[15:0]), 72'(0));
    waitCycles(2);
    areset = 1'b0;
    egr_cap.delete();
    dpr_cap.delete();
    applyStimulus(3, 10, 2);
    applyStimulus(1, 10, 2);
    expectPacket(0, 1, 10, 2);
    expectPacket(0, 3, 10, 2);
    waitDone("post_rst", 4, 0, 40);
    checkStreams("post_rst");

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
